// File: rtl/mem_lsu_stage.sv
// MEM-stage load/store unit: turns one load/store request into a held, lane-aligned
// data-memory transaction and returns an extracted, extended load result to WB.
module mem_lsu_stage #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_load_i,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              stall_o,
  output logic              dmem_read_o,
  output logic              dmem_write_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [LANES-1:0]  dmem_byte_en_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_resp_i,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic [4:0]        load_rd_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [OFF_W-1:0]  r_offset;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;

  logic              w_accept, w_illegal, w_misaligned, w_legal;
  logic [OFF_W-1:0]  w_offset;
  logic [LANES-1:0]  w_size_mask;
  logic [DATA_W-1:0] w_shifted, w_load_ext;
  logic              w_sign;

  assign w_offset = req_addr_i[OFF_W-1:0];
  assign w_accept = (r_state != S_BUSY) & req_valid_i & (req_load_i | req_store_i);

  // 011/110 are the 64-bit-only LD/LWU encodings
  assign w_illegal = ((DATA_W == 32) && (req_funct3_i == 3'b011 || req_funct3_i == 3'b110))
                   || (req_funct3_i == 3'b111)
                   || (req_store_i && req_funct3_i[2]);

  always_comb begin
    w_misaligned = 1'b0;
    w_size_mask  = LANES'(8'h01);
    case (req_funct3_i[1:0])
      2'b00: w_size_mask = LANES'(8'h01);
      2'b01: begin w_size_mask = LANES'(8'h03); w_misaligned = req_addr_i[0]; end
      2'b10: begin w_size_mask = LANES'(8'h0F); w_misaligned = |req_addr_i[1:0]; end
      default: begin w_size_mask = LANES'(8'hFF); w_misaligned = |req_addr_i[2:0]; end
    endcase
  end

  assign w_legal = ~w_illegal & ~w_misaligned;
  assign stall_o = (w_accept & w_legal) | ((r_state == S_BUSY) & ~dmem_resp_i);

  assign w_shifted = dmem_rdata_i >> {r_offset, 3'b000};

  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_sign = w_shifted[7];
      2'b01:   w_sign = w_shifted[15];
      2'b10:   w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    w_sign     = w_sign & ~r_f3[2];
    w_load_ext = w_shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= (8 << r_f3[1:0])) w_load_ext[i] = w_sign;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BUSY:  w_state_nxt = dmem_resp_i ? S_DONE : S_BUSY;
      default: w_state_nxt = (w_accept && w_legal) ? S_BUSY : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_read_o    <= 1'b0;
      dmem_write_o   <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_wdata_o   <= '0;
      dmem_byte_en_o <= '0;
      load_valid_o   <= 1'b0;
      load_data_o    <= '0;
      load_rd_o      <= '0;
      fault_o        <= 1'b0;
      r_offset       <= '0;
      r_f3           <= '0;
      r_rd           <= '0;
    end else begin
      load_valid_o <= 1'b0;
      fault_o      <= 1'b0;
      if (r_state == S_BUSY) begin
        if (dmem_resp_i) begin
          dmem_read_o  <= 1'b0;
          dmem_write_o <= 1'b0;
          if (dmem_read_o) begin
            load_valid_o <= 1'b1;
            load_data_o  <= w_load_ext;
            load_rd_o    <= r_rd;
          end
        end
      end else if (w_accept) begin
        if (w_legal) begin
          dmem_read_o    <= req_load_i;
          dmem_write_o   <= req_store_i;
          dmem_addr_o    <= {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
          dmem_wdata_o   <= req_wdata_i << {w_offset, 3'b000};
          dmem_byte_en_o <= w_size_mask << w_offset;
          r_offset       <= w_offset;
          r_f3           <= req_funct3_i;
          r_rd           <= req_rd_i;
        end else begin
          fault_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed self-checking bench for mem_lsu_stage at DATA_W=32 (instance a) and 64 (instance b).
module tb_mem_lsu_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_valid, a_load, a_store, a_resp;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [4:0]  a_rd;
  logic        a_stall, a_read, a_write, a_lvalid, a_fault;
  logic [31:0] a_daddr, a_dwdata, a_ldata;
  logic [3:0]  a_be;
  logic [4:0]  a_lrd;

  logic        b_valid, b_load, b_store, b_resp;
  logic [2:0]  b_f3;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic [4:0]  b_rd;
  logic        b_stall, b_read, b_write, b_lvalid, b_fault;
  logic [31:0] b_daddr;
  logic [63:0] b_dwdata, b_ldata;
  logic [7:0]  b_be;
  logic [4:0]  b_lrd;

  mem_lsu_stage #(.DATA_W(32), .ADDR_W(32)) u_a (
    .clk(clk), .rst(rst), .req_valid_i(a_valid), .req_load_i(a_load), .req_store_i(a_store),
    .req_funct3_i(a_f3), .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_rd_i(a_rd),
    .stall_o(a_stall), .dmem_read_o(a_read), .dmem_write_o(a_write), .dmem_addr_o(a_daddr),
    .dmem_wdata_o(a_dwdata), .dmem_byte_en_o(a_be), .dmem_rdata_i(a_rdata), .dmem_resp_i(a_resp),
    .load_valid_o(a_lvalid), .load_data_o(a_ldata), .load_rd_o(a_lrd), .fault_o(a_fault));

  mem_lsu_stage #(.DATA_W(64), .ADDR_W(32)) u_b (
    .clk(clk), .rst(rst), .req_valid_i(b_valid), .req_load_i(b_load), .req_store_i(b_store),
    .req_funct3_i(b_f3), .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_rd_i(b_rd),
    .stall_o(b_stall), .dmem_read_o(b_read), .dmem_write_o(b_write), .dmem_addr_o(b_daddr),
    .dmem_wdata_o(b_dwdata), .dmem_byte_en_o(b_be), .dmem_rdata_i(b_rdata), .dmem_resp_i(b_resp),
    .load_valid_o(b_lvalid), .load_data_o(b_ldata), .load_rd_o(b_lrd), .fault_o(b_fault));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    a_valid = 1'b1; a_load = ld; a_store = ~ld; a_f3 = f3; a_addr = addr; a_wdata = wd; a_rd = rd;
  endtask

  task automatic b_req(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [4:0] rd);
    b_valid = 1'b1; b_load = ld; b_store = ~ld; b_f3 = f3; b_addr = addr; b_wdata = wd; b_rd = rd;
  endtask

  task automatic test_reset();
    a_valid = 0; a_load = 0; a_store = 0; a_f3 = 0; a_addr = 0; a_wdata = 0; a_rd = 0;
    a_rdata = 0; a_resp = 0;
    b_valid = 0; b_load = 0; b_store = 0; b_f3 = 0; b_addr = 0; b_wdata = 0; b_rd = 0;
    b_rdata = 0; b_resp = 0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({a_stall, a_read, a_write, a_lvalid, a_fault} !== 5'b0 || a_daddr !== 32'h0 ||
        a_dwdata !== 32'h0 || a_be !== 4'h0 || a_ldata !== 32'h0 || a_lrd !== 5'h0) begin
      errors++; $display("FAIL reset_a got ctl=%b addr=%h wd=%h be=%h ld=%h rd=%h exp all zero",
        {a_stall, a_read, a_write, a_lvalid, a_fault}, a_daddr, a_dwdata, a_be, a_ldata, a_lrd);
    end
    checks++;
    if ({b_stall, b_read, b_write, b_lvalid, b_fault} !== 5'b0 || b_be !== 8'h0 || b_ldata !== 64'h0) begin
      errors++; $display("FAIL reset_b got ctl=%b be=%h ld=%h exp all zero",
        {b_stall, b_read, b_write, b_lvalid, b_fault}, b_be, b_ldata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lb();
    int stall_cnt = 0;
    a_req(1'b1, 3'b000, 32'h1003, 32'h0, 5'd5);
    #1;
    if (a_stall) stall_cnt++;
    tick();
    a_valid = 0;
    if (a_stall) stall_cnt++;
    checks++;
    if (a_read !== 1'b1 || a_write !== 1'b0 || a_daddr !== 32'h1000 || a_be !== 4'h8) begin
      errors++; $display("FAIL lb_issue got rd=%b wr=%b addr=%h be=%h exp 1 0 00001000 8",
        a_read, a_write, a_daddr, a_be);
    end
    tick();
    if (a_stall) stall_cnt++;
    checks++;
    if (a_read !== 1'b1 || a_daddr !== 32'h1000) begin
      errors++; $display("FAIL lb_hold got rd=%b addr=%h exp 1 00001000", a_read, a_daddr);
    end
    tick();
    a_rdata = 32'h80FF_1234; a_resp = 1'b1;
    #1;
    if (a_stall) stall_cnt++;
    checks++;
    if (stall_cnt !== 3) begin
      errors++; $display("FAIL lb_stall_cycles got %0d exp 3", stall_cnt);
    end
    tick();
    a_resp = 0;
    checks++;
    if (a_lvalid !== 1'b1 || a_ldata !== 32'hFFFF_FF80 || a_lrd !== 5'd5 || a_read !== 1'b0) begin
      errors++; $display("FAIL lb_data got v=%b d=%h rd=%0d read=%b exp 1 ffffff80 5 0",
        a_lvalid, a_ldata, a_lrd, a_read);
    end
    tick();
    checks++;
    if (a_lvalid !== 1'b0) begin
      errors++; $display("FAIL lb_pulse got %b exp 0", a_lvalid);
    end
  endtask

  task automatic test_sh();
    a_req(1'b0, 3'b001, 32'h2002, 32'h0000_BEEF, 5'd0);
    tick();
    a_valid = 0;
    checks++;
    if (a_write !== 1'b1 || a_read !== 1'b0 || a_be !== 4'hC || a_dwdata !== 32'hBEEF_0000 ||
        a_daddr !== 32'h2000) begin
      errors++; $display("FAIL sh_issue got wr=%b rd=%b be=%h wd=%h addr=%h exp 1 0 c beef0000 00002000",
        a_write, a_read, a_be, a_dwdata, a_daddr);
    end
    tick(); tick();
    checks++;
    if (a_write !== 1'b1 || a_dwdata !== 32'hBEEF_0000 || a_be !== 4'hC || a_stall !== 1'b1) begin
      errors++; $display("FAIL sh_hold got wr=%b wd=%h be=%h stall=%b exp 1 beef0000 c 1",
        a_write, a_dwdata, a_be, a_stall);
    end
    a_resp = 1'b1;
    tick();
    a_resp = 0;
    checks++;
    if (a_write !== 1'b0 || a_lvalid !== 1'b0) begin
      errors++; $display("FAIL sh_done got wr=%b lv=%b exp 0 0", a_write, a_lvalid);
    end
    tick();
  endtask

  task automatic test_fault();
    a_req(1'b1, 3'b010, 32'h3001, 32'h0, 5'd3);
    #1;
    checks++;
    if (a_stall !== 1'b0) begin
      errors++; $display("FAIL fault_stall got %b exp 0", a_stall);
    end
    tick();
    a_valid = 0;
    checks++;
    if (a_fault !== 1'b1 || a_read !== 1'b0) begin
      errors++; $display("FAIL fault_lw got f=%b rd=%b exp 1 0", a_fault, a_read);
    end
    tick();
    checks++;
    if (a_fault !== 1'b0 || a_read !== 1'b0 || a_lvalid !== 1'b0) begin
      errors++; $display("FAIL fault_pulse got f=%b rd=%b lv=%b exp 0 0 0", a_fault, a_read, a_lvalid);
    end
    a_req(1'b0, 3'b100, 32'h3000, 32'h1, 5'd0);
    tick();
    a_valid = 0;
    checks++;
    if (a_fault !== 1'b1 || a_write !== 1'b0) begin
      errors++; $display("FAIL fault_store_u got f=%b wr=%b exp 1 0", a_fault, a_write);
    end
    a_req(1'b1, 3'b011, 32'h3000, 32'h0, 5'd1);
    tick();
    a_valid = 0;
    checks++;
    if (a_fault !== 1'b1 || a_read !== 1'b0) begin
      errors++; $display("FAIL fault_ld32 got f=%b rd=%b exp 1 0", a_fault, a_read);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    a_req(1'b1, 3'b101, 32'h10, 32'h0, 5'd7);
    tick();
    a_valid = 0;
    a_rdata = 32'hA5A5_8001; a_resp = 1'b1;
    #1;
    checks++;
    if (a_stall !== 1'b0 || a_read !== 1'b1 || a_be !== 4'h3) begin
      errors++; $display("FAIL b2b_lhu got stall=%b rd=%b be=%h exp 0 1 3", a_stall, a_read, a_be);
    end
    tick();
    a_resp = 0;
    a_req(1'b0, 3'b010, 32'h14, 32'h1234_5678, 5'd0);
    #1;
    checks++;
    if (a_lvalid !== 1'b1 || a_ldata !== 32'h0000_8001 || a_lrd !== 5'd7 || a_stall !== 1'b1) begin
      errors++; $display("FAIL b2b_done got lv=%b d=%h rd=%0d stall=%b exp 1 00008001 7 1",
        a_lvalid, a_ldata, a_lrd, a_stall);
    end
    tick();
    a_valid = 0;
    checks++;
    if (a_write !== 1'b1 || a_daddr !== 32'h14 || a_be !== 4'hF || a_dwdata !== 32'h1234_5678 ||
        a_lvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_sw got wr=%b addr=%h be=%h wd=%h lv=%b exp 1 00000014 f 12345678 0",
        a_write, a_daddr, a_be, a_dwdata, a_lvalid);
    end
    a_resp = 1'b1;
    tick();
    a_resp = 0;
    tick();
  endtask

  task automatic test_reset_busy();
    a_req(1'b0, 3'b000, 32'h21, 32'h55, 5'd0);
    tick();
    a_valid = 0;
    checks++;
    if (a_write !== 1'b1 || a_be !== 4'h2 || a_dwdata !== 32'h0000_5500) begin
      errors++; $display("FAIL rstb_sb got wr=%b be=%h wd=%h exp 1 2 00005500", a_write, a_be, a_dwdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (a_write !== 1'b0 || a_stall !== 1'b0 || a_lvalid !== 1'b0) begin
      errors++; $display("FAIL rstb_clear got wr=%b stall=%b lv=%b exp 0 0 0", a_write, a_stall, a_lvalid);
    end
    a_resp = 1'b1;
    tick();
    a_resp = 0;
    checks++;
    if (a_lvalid !== 1'b0 || a_write !== 1'b0) begin
      errors++; $display("FAIL rstb_idle_resp got lv=%b wr=%b exp 0 0", a_lvalid, a_write);
    end
    a_req(1'b1, 3'b010, 32'h40, 32'h0, 5'd9);
    tick();
    a_valid = 0;
    checks++;
    if (a_read !== 1'b1 || a_be !== 4'hF || a_daddr !== 32'h40) begin
      errors++; $display("FAIL rstb_lw_issue got rd=%b be=%h addr=%h exp 1 f 00000040", a_read, a_be, a_daddr);
    end
    a_rdata = 32'hDEAD_BEEF; a_resp = 1'b1;
    tick();
    a_resp = 0;
    checks++;
    if (a_lvalid !== 1'b1 || a_ldata !== 32'hDEAD_BEEF || a_lrd !== 5'd9) begin
      errors++; $display("FAIL rstb_lw_data got lv=%b d=%h rd=%0d exp 1 deadbeef 9", a_lvalid, a_ldata, a_lrd);
    end
    tick();
  endtask

  task automatic test_dw64();
    b_req(1'b1, 3'b011, 32'h8, 64'h0, 5'd2);
    tick();
    b_valid = 0;
    checks++;
    if (b_read !== 1'b1 || b_be !== 8'hFF || b_daddr !== 32'h8) begin
      errors++; $display("FAIL ld64_issue got rd=%b be=%h addr=%h exp 1 ff 00000008", b_read, b_be, b_daddr);
    end
    b_rdata = 64'h0123_4567_89AB_CDEF; b_resp = 1'b1;
    tick();
    b_resp = 0;
    b_req(1'b1, 3'b110, 32'h4, 64'h0, 5'd4);
    checks++;
    if (b_lvalid !== 1'b1 || b_ldata !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL ld64_data got lv=%b d=%h exp 1 0123456789abcdef", b_lvalid, b_ldata);
    end
    tick();
    b_valid = 0;
    checks++;
    if (b_read !== 1'b1 || b_be !== 8'hF0 || b_daddr !== 32'h0) begin
      errors++; $display("FAIL lwu64_issue got rd=%b be=%h addr=%h exp 1 f0 00000000", b_read, b_be, b_daddr);
    end
    b_rdata = 64'hFFFF_FFFF_0000_0000; b_resp = 1'b1;
    tick();
    b_resp = 0;
    checks++;
    if (b_lvalid !== 1'b1 || b_ldata !== 64'h0000_0000_FFFF_FFFF || b_lrd !== 5'd4) begin
      errors++; $display("FAIL lwu64_data got lv=%b d=%h rd=%0d exp 1 00000000ffffffff 4", b_lvalid, b_ldata, b_lrd);
    end
    tick();
    b_req(1'b1, 3'b010, 32'h4, 64'h0, 5'd6);
    tick();
    b_valid = 0;
    b_rdata = 64'h8000_0000_0000_0000; b_resp = 1'b1;
    tick();
    b_resp = 0;
    checks++;
    if (b_lvalid !== 1'b1 || b_ldata !== 64'hFFFF_FFFF_8000_0000) begin
      errors++; $display("FAIL lw64_sext got lv=%b d=%h exp 1 ffffffff80000000", b_lvalid, b_ldata);
    end
    tick();
    b_req(1'b0, 3'b011, 32'h10, 64'hCAFE_F00D_1234_5678, 5'd0);
    tick();
    b_valid = 0;
    checks++;
    if (b_write !== 1'b1 || b_be !== 8'hFF || b_dwdata !== 64'hCAFE_F00D_1234_5678) begin
      errors++; $display("FAIL sd64_issue got wr=%b be=%h wd=%h exp 1 ff cafef00d12345678", b_write, b_be, b_dwdata);
    end
    b_resp = 1'b1;
    tick();
    b_resp = 0;
    tick();
    b_req(1'b1, 3'b011, 32'h4, 64'h0, 5'd1);
    tick();
    b_valid = 0;
    checks++;
    if (b_fault !== 1'b1 || b_read !== 1'b0) begin
      errors++; $display("FAIL ld64_misalign got f=%b rd=%b exp 1 0", b_fault, b_read);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_fault();
    test_back_to_back();
    test_reset_busy();
    test_dw64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
